// File: rtl/cceip_kernel_pkg.sv
// Shared types and helpers for the CCEIP kernel core.
package cceip_kernel_pkg;

  // Bytes carried by one 64-bit stream beat.
  localparam int BEAT_BYTES = 8;

  // Output-collector job states.
  typedef enum logic [2:0] {
    IDLE,
    PASS,
    PAD,
    DRAIN,
    DONE
  } ob_col_state_t;

  // Number of set bits in an 8-bit byte-strobe field.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/cceip_ob_collector.sv
// Forwards the CCEIP output stream to the write master, zero-pads each job
// to the programmed capacity, counts payload bytes and drains any excess.
module cceip_ob_collector
  import cceip_kernel_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SIZE_W = 64
) (
  input  logic                ap_clk,
  input  logic                areset,
  input  logic                start,
  input  logic [SIZE_W-1:0]   capacity_bytes,
  output logic                busy,
  output logic                done,
  output logic [SIZE_W-1:0]   out_bytes,
  output logic                overflow,
  input  logic                ob_tvalid,
  output logic                ob_tready,
  input  logic [DATA_W-1:0]   ob_tdata,
  input  logic [DATA_W/8-1:0] ob_tstrb,
  input  logic                ob_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata
);

  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  ob_col_state_t     state_reg;
  logic [SIZE_W-1:0] cap_beats_reg;
  logic [SIZE_W-1:0] beat_cnt_reg;
  logic [SIZE_W-1:0] out_bytes_reg;
  logic              overflow_reg;

  logic [SIZE_W-1:0] cap_beats_next;
  logic [SIZE_W-1:0] beat_cnt_inc;
  logic              at_cap;
  logic              ob_hs;
  logic              m_hs;

  // Capacity rounded up to whole beats, evaluated on the launch cycle.
  assign cap_beats_next = (capacity_bytes + SIZE_W'(BEAT_BYTES - 1)) >> BEAT_SHIFT;
  assign beat_cnt_inc   = beat_cnt_reg + SIZE_W'(1);
  assign at_cap         = (beat_cnt_inc == cap_beats_reg);
  assign ob_hs          = ob_tvalid && ob_tready;
  assign m_hs           = m_axis_tvalid && m_axis_tready;

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign out_bytes = out_bytes_reg;
  assign overflow  = overflow_reg;

  // Stream steering: ob_tready never looks at ob_tvalid, only at state and
  // the downstream ready, so there is no valid-to-ready loop.
  always_comb begin
    ob_tready     = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    case (state_reg)
      PASS: begin
        m_axis_tvalid = ob_tvalid;
        m_axis_tdata  = ob_tdata;
        ob_tready     = m_axis_tready;
      end
      PAD: begin
        m_axis_tvalid = 1'b1;
      end
      DRAIN: begin
        ob_tready = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Job sequencing, beat accounting and byte/overflow bookkeeping.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_reg     <= IDLE;
      cap_beats_reg <= '0;
      beat_cnt_reg  <= '0;
      out_bytes_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cap_beats_reg <= cap_beats_next;
            beat_cnt_reg  <= '0;
            out_bytes_reg <= '0;
            overflow_reg  <= 1'b0;
            state_reg     <= (cap_beats_next == '0) ? DRAIN : PASS;
          end
        end
        PASS: begin
          if (ob_hs) begin
            beat_cnt_reg  <= beat_cnt_inc;
            out_bytes_reg <= out_bytes_reg + SIZE_W'(popcount8(ob_tstrb));
            if (at_cap) begin
              state_reg <= ob_tlast ? DONE : DRAIN;
            end else if (ob_tlast) begin
              state_reg <= PAD;
            end
          end
        end
        PAD: begin
          if (m_hs) begin
            beat_cnt_reg <= beat_cnt_inc;
            if (at_cap) begin
              state_reg <= DONE;
            end
          end
        end
        DRAIN: begin
          if (ob_hs) begin
            overflow_reg <= 1'b1;
            if (ob_tlast) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cceip_ob_collector.md
# cceip_ob_collector

Downstream stage of the CCEIP engine inside the kernel core: consumes the `cr_cceip_64` output stream (`ob_*`) and forwards it to the AXI4 write master's stream input. The kernel programs the write master with a fixed output capacity, so this block zero-pads every job up to exactly that many beats. While doing so it counts the real payload bytes, and the kernel later writes that count to `output_size_addr`. Data beyond capacity is drained from CCEIP and flagged, never written.

## Interface

Parameters:
- `DATA_W`, 64: stream data width; fixed at 64 (strobe 8 bits).
- `SIZE_W`, 64: width of the capacity and byte-count fields.

Ports:
- `ap_clk`, in, 1: the block's single clock.
- `areset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle job launch; sampled only in IDLE.
- `capacity_bytes`, in, SIZE_W: output buffer size; captured on `start`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at job end.
- `out_bytes`, out, SIZE_W: payload bytes forwarded; valid from `done` until the next `start`.
- `overflow`, out, 1: CCEIP produced more beats than capacity; valid with `out_bytes`.
- `ob_tvalid`, in, 1: CCEIP output valid.
- `ob_tready`, out, 1: ready back to CCEIP.
- `ob_tdata`, in, 64: CCEIP output data.
- `ob_tstrb`, in, 8: byte strobes for the beat.
- `ob_tlast`, in, 1: last beat of the job.
- `m_axis_tvalid`, out, 1: valid to the write master.
- `m_axis_tready`, in, 1: ready from the write master.
- `m_axis_tdata`, out, 64: data to the write master.

## Operation

- `cap_beats = ceil(capacity_bytes/8)`, computed at `start` as `(capacity_bytes+7)>>3` at SIZE_W width. `beat_cnt` is SIZE_W wide.
- States:
  - IDLE: on `start`, capture capacity and clear `beat_cnt`, `out_bytes` and `overflow`. Go to DRAIN if `cap_beats==0`, else to PASS.
  - PASS: the ob stream passes through combinationally.
    - `m_axis_tvalid=ob_tvalid`, `m_axis_tdata=ob_tdata`, `ob_tready=m_axis_tready`.
    - On each handshake, `beat_cnt+=1` and `out_bytes+=popcount(ob_tstrb)`.
    - Handshake with `tlast` and `beat_cnt+1==cap_beats` goes to DONE.
    - Handshake with `tlast` and fewer beats goes to PAD.
    - Handshake without `tlast` that reaches `beat_cnt+1==cap_beats` goes to DRAIN.
  - PAD: `m_axis_tvalid=1`, `m_axis_tdata=0`, `ob_tready=0`. Each handshake does `beat_cnt+=1`; reaching `cap_beats` goes to DONE.
  - DRAIN: `ob_tready=1`, `m_axis_tvalid=0`. Every accepted beat sets `overflow` and does not add to `out_bytes`. An accepted `tlast` goes to DONE.
  - DONE: `done=1` for one cycle, then IDLE.
- Outside PASS and DRAIN, `ob_tready=0`. Outside PASS and PAD, `m_axis_tvalid=0` and `m_axis_tdata=0`.
- Strobes are counted with popcount; non-contiguous strobes are counted, not rejected.
- `start` while busy is ignored.
- The write master always receives exactly `cap_beats` beats per job.

## Timing

- Reset clears all of the following; `out_bytes` reads 0 after reset:
  - state goes to IDLE;
  - `busy`, `done`, `overflow`, `ob_tready`, `m_axis_tvalid` go to 0;
  - `m_axis_tdata` goes to 0;
  - `out_bytes` and `beat_cnt` go to 0.
- Reset mid-job abandons the job; no `done` is produced.
- `busy` rises the cycle after `start`.
- PASS has zero latency from ob to m_axis. There is no combinational path from `ob_tvalid` to `ob_tready`.
- Padding beats: one per cycle while `m_axis_tready=1`.
- `done` asserts the cycle after the final handshake, and `out_bytes`/`overflow` are already final in that cycle.
- Minimum job length is 3 cycles: start, one beat with `tlast` at capacity 8, done.
- AXIS rule: once asserted, `m_axis_tvalid` holds with stable data until `m_axis_tready`. In PASS this follows from CCEIP obeying the same rule.

## Structure

- Add to the shared package `cceip_kernel_pkg`:
  - state enum `ob_col_state_t` {IDLE, PASS, PAD, DRAIN, DONE};
  - `function popcount8`;
  - localparam `BEAT_BYTES=8`.
- Single flat module, no sub-module. The kernel core's write-data states instantiate it between `cr_cceip_64` `ob_*` and the write master `s_axis_*`.

## Test plan

- Capacity 32, CCEIP sends 2 beats with strobes 0xFF then 0x0F (`tlast`) -> 4 m_axis beats (2 payload, 2 zero), `out_bytes=12`, `overflow=0`, one `done`.
- Capacity 16, exactly 2 full beats with `tlast` on beat 2 -> no PAD, `done` the cycle after beat 2, `out_bytes=16`.
- Capacity 16, 5 beats (`tlast` on beat 5) -> 2 beats forwarded, 3 drained, `overflow=1`, `out_bytes=16`.
- Capacity 0, 1 beat with `tlast` -> no m_axis beats, `overflow=1`, `out_bytes=0`.
- Capacity 20 (rounds to 3 beats), `m_axis_tready` toggled every cycle -> 3 beats with data held stable while stalled, `start` pulsed while busy is ignored.
- `areset` asserted during PAD -> next cycle all outputs 0; a new job afterwards with capacity 8 completes normally.
